// File: rtl/sram1d_port_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: FSM states and requester indices.
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/sram1d_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the input that was not granted most recently.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt
);

  // 1 = REQ1 was granted last, so REQ0 wins the first tie after reset.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req[REQ0] && (!req[REQ1] || last_q)) begin
      gnt[REQ0] = 1'b1;
    end else if (req[REQ1]) begin
      gnt[REQ1] = 1'b1;
    end
    if (update_en && (gnt != 2'b00)) begin
      last_d = gnt[REQ1];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram1d_port_arbiter.sv
// Shares one single-port SRAM between two requesters: optional zero-fill after reset,
// then one round-robin-arbitrated access per cycle with a one-cycle read return.
module sram1d_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DWidth   = 32,
  parameter int unsigned AWidth   = 10,
  parameter bit          InitZero = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              InitDone,
  input  logic              R0Valid,
  input  logic              R1Valid,
  output logic              R0Ready,
  output logic              R1Ready,
  input  logic              R0Write,
  input  logic              R1Write,
  input  logic [AWidth-1:0] R0Address,
  input  logic [AWidth-1:0] R1Address,
  input  logic [DWidth-1:0] R0DIn,
  input  logic [DWidth-1:0] R1DIn,
  output logic              R0DOutValid,
  output logic              R1DOutValid,
  output logic [DWidth-1:0] RDOut,
  output logic              SEnable,
  output logic              SWrite,
  output logic [AWidth-1:0] SAddress,
  output logic [DWidth-1:0] SDIn,
  input  logic [DWidth-1:0] SDOut
);

  state_e              state_q, state_d;
  logic [AWidth-1:0]   cnt_q, cnt_d;
  logic                r0_vld_q, r0_vld_d;
  logic                r1_vld_q, r1_vld_d;
  logic [AWidth-1:0]   addr_q, addr_d;
  logic [DWidth-1:0]   din_q, din_d;
  logic                run_active;
  logic [1:0]          gnt;

  assign run_active = (state_q == ST_RUN) && !Reset;

  rr_arb2 u_rr_arb2 (
    .clk       (Clock),
    .srst      (Reset),
    .req       ({R1Valid, R0Valid} & {2{run_active}}),
    .update_en (run_active),
    .gnt       (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r0_vld_d = 1'b0;
    r1_vld_d = 1'b0;
    SEnable  = 1'b0;
    SWrite   = 1'b0;
    SAddress = addr_q;
    SDIn     = din_q;
    R0Ready  = 1'b0;
    R1Ready  = 1'b0;
    if (!Reset) begin
      if (state_q == ST_INIT) begin
        SEnable  = 1'b1;
        SWrite   = 1'b1;
        SAddress = cnt_q;
        SDIn     = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {AWidth{1'b1}}) begin
          state_d = ST_RUN;
        end
      end else begin
        R0Ready = gnt[REQ0];
        R1Ready = gnt[REQ1];
        if (gnt[REQ0]) begin
          SEnable  = 1'b1;
          SWrite   = R0Write;
          SAddress = R0Address;
          SDIn     = R0DIn;
          r0_vld_d = !R0Write;
        end else if (gnt[REQ1]) begin
          SEnable  = 1'b1;
          SWrite   = R1Write;
          SAddress = R1Address;
          SDIn     = R1DIn;
          r1_vld_d = !R1Write;
        end
      end
    end
    // Idle cycles keep the pins parked on the last access to avoid needless toggling.
    addr_d = SEnable ? SAddress : addr_q;
    din_d  = SEnable ? SDIn : din_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= (InitZero != 1'b0) ? ST_INIT : ST_RUN;
      cnt_q    <= '0;
      r0_vld_q <= 1'b0;
      r1_vld_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r0_vld_q <= r0_vld_d;
      r1_vld_q <= r1_vld_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  // Reset overrides the response flags so a pending read is dropped immediately.
  assign InitDone    = (state_q == ST_RUN) && !Reset;
  assign R0DOutValid = r0_vld_q && !Reset;
  assign R1DOutValid = r1_vld_q && !Reset;
  assign RDOut       = SDOut;

endmodule

// File: tb/tb_sram1d_port_arbiter.sv
// Bench for sram1d_port_arbiter: behavioural SRAM, reference model for grants/responses,
// directed plus random traffic.
module tb_sram1d_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done, nz_init_done;
  logic          r0_valid, r1_valid, r0_write, r1_write;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_din, r1_din;
  logic          r0_ready, r1_ready, r0_dv, r1_dv;
  logic [DW-1:0] rdout, sdin, sdout;
  logic          sen, swr;
  logic [AW-1:0] saddr;

  logic          nz_r0_ready, nz_r1_ready, nz_r0_dv, nz_r1_dv, nz_sen, nz_swr;
  logic [DW-1:0] nz_rdout, nz_sdin;
  logic [AW-1:0] nz_saddr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_last_r1;
  logic          exp_v0, exp_v1;
  logic [DW-1:0] exp_dat;

  // Behavioural single-port SRAM attached to the DUT pins
  logic [DW-1:0] sram_mem [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sen) begin
      if (swr) sram_mem[saddr] <= sdin;
      else     sdout <= sram_mem[saddr];
    end
  end

  sram1d_port_arbiter #(.DWidth(DW), .AWidth(AW), .InitZero(1'b1)) u_dut (
    .Clock(clk), .Reset(rst), .InitDone(init_done),
    .R0Valid(r0_valid), .R1Valid(r1_valid), .R0Ready(r0_ready), .R1Ready(r1_ready),
    .R0Write(r0_write), .R1Write(r1_write), .R0Address(r0_addr), .R1Address(r1_addr),
    .R0DIn(r0_din), .R1DIn(r1_din), .R0DOutValid(r0_dv), .R1DOutValid(r1_dv),
    .RDOut(rdout), .SEnable(sen), .SWrite(swr), .SAddress(saddr), .SDIn(sdin), .SDOut(sdout)
  );

  sram1d_port_arbiter #(.DWidth(DW), .AWidth(AW), .InitZero(1'b0)) u_dut_nz (
    .Clock(clk), .Reset(rst), .InitDone(nz_init_done),
    .R0Valid(r0_valid), .R1Valid(r1_valid), .R0Ready(nz_r0_ready), .R1Ready(nz_r1_ready),
    .R0Write(r0_write), .R1Write(r1_write), .R0Address(r0_addr), .R1Address(r1_addr),
    .R0DIn(r0_din), .R1DIn(r1_din), .R0DOutValid(nz_r0_dv), .R1DOutValid(nz_r1_dv),
    .RDOut(nz_rdout), .SEnable(nz_sen), .SWrite(nz_swr), .SAddress(nz_saddr), .SDIn(nz_sdin),
    .SDOut({DW{1'b0}})
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Entered and left at a falling edge; Reset is sampled by exactly one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_nz_init_done", nz_init_done, 0);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_r0_dv", r0_dv, 0);
    chk("rst_r1_dv", r1_dv, 0);
    chk("rst_sen", sen, 0);
    $display("reset asserted");
    @(negedge clk);
    rst = 1'b0;
    ref_last_r1 = 1'b1;
    exp_v0 = 1'b0; exp_v1 = 1'b0;
    #1;
    chk("nz_init_done_cycle1", nz_init_done, 1);
  endtask

  task automatic init_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_sen", sen, 1);
      chk("init_swr", swr, 1);
      chk("init_saddr", saddr, i);
      chk("init_sdin", sdin, 0);
      chk("init_r0_ready", r0_ready, 0);
      chk("init_r1_ready", r1_ready, 0);
      chk("init_done_low", init_done, 0);
      ref_mem[i] = '0;
      @(negedge clk);
    end
    $display("init: %0d zero writes observed", n);
  endtask

  // One RUN cycle: drive both requesters, compare against the reference, advance the model.
  task automatic step(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic g0, g1;
    r0_valid = v0; r0_write = w0; r0_addr = a0; r0_din = d0;
    r1_valid = v1; r1_write = w1; r1_addr = a1; r1_din = d1;
    #1;
    g0 = v0 && (!v1 || ref_last_r1);
    g1 = v1 && !g0;
    chk("run_init_done", init_done, 1);
    chk("r0_ready", r0_ready, g0);
    chk("r1_ready", r1_ready, g1);
    chk("r0_dout_valid", r0_dv, exp_v0);
    chk("r1_dout_valid", r1_dv, exp_v1);
    if (exp_v0 || exp_v1) chk("rdout", rdout, exp_dat);
    chk("sen", sen, g0 | g1);
    if (g0 || g1) begin
      chk("swr", swr, g0 ? w0 : w1);
      chk("saddr", saddr, g0 ? a0 : a1);
      if (g0 ? w0 : w1) chk("sdin", sdin, g0 ? d0 : d1);
    end
    $display("step v0=%0d w0=%0d a0=%0d v1=%0d w1=%0d a1=%0d -> grant r0=%0d r1=%0d",
             v0, w0, a0, v1, w1, a1, r0_ready, r1_ready);
    exp_v0 = g0 && !w0;
    exp_v1 = g1 && !w1;
    if (g0) begin
      if (w0) ref_mem[a0] = d0; else exp_dat = ref_mem[a0];
    end else if (g1) begin
      if (w1) ref_mem[a1] = d1; else exp_dat = ref_mem[a1];
    end
    if (g0 || g1) ref_last_r1 = g1;
    @(negedge clk);
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; r0_write = 1'b0; r1_write = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_din = '0; r1_din = '0;
    ref_last_r1 = 1'b1; exp_v0 = 1'b0; exp_v1 = 1'b0; exp_dat = '0;
    @(negedge clk);
    @(negedge clk);

    // Zero-fill with a read request pending throughout INIT
    do_reset();
    r0_valid = 1'b1; r0_write = 1'b0; r0_addr = AW'(77);
    init_cycles(DEPTH);
    step(1, 0, 77, 0, 0, 0, 0, 0);

    // Write then read of the same address
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous contention alternates between requesters
    step(0, 0, 0, 0, 1, 1, 9, 32'h0000_1234);
    for (int i = 0; i < 6; i++) step(1, 0, 5, 0, 1, 0, 9, 0);

    // Same-address read (R0) and write (R1) are serialized
    step(1, 0, 3, 0, 1, 1, 3, 32'hA5A5_0003);
    step(0, 0, 0, 0, 1, 1, 3, 32'hA5A5_0003);
    step(1, 0, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    random_steps(200);

    // Reset right after an accepted read drops the response
    step(0, 0, 0, 0, 1, 0, 9, 0);
    do_reset();

    // Reset in the middle of zero-fill restarts it from address 0
    init_cycles(40);
    do_reset();
    init_cycles(DEPTH);
    step(1, 0, 77, 0, 0, 0, 0, 0);
    random_steps(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
